// File: rtl/axil_status_slave.sv
// AXI4-Lite target for the STATUS window: CTRL/STATUS registers plus a FIFO behind DATA.
// Writes commit one edge after both AW and W are latched; reads respond one edge after AR.
module axil_status_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h0000_4000,
    parameter int                DEPTH     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   s_axil_awaddr,
    input  logic                s_axil_awvalid,
    output logic                s_axil_awready,
    input  logic [DATA_W-1:0]   s_axil_wdata,
    input  logic [DATA_W/8-1:0] s_axil_wstrb,
    input  logic                s_axil_wvalid,
    output logic                s_axil_wready,
    output logic [1:0]          s_axil_bresp,
    output logic                s_axil_bvalid,
    input  logic                s_axil_bready,
    input  logic [ADDR_W-1:0]   s_axil_araddr,
    input  logic                s_axil_arvalid,
    output logic                s_axil_arready,
    output logic [DATA_W-1:0]   s_axil_rdata,
    output logic [1:0]          s_axil_rresp,
    output logic                s_axil_rvalid,
    input  logic                s_axil_rready,
    output logic                irq_not_empty
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [11:0] OFF_CTRL    = 12'h000;
    localparam logic [11:0] OFF_STATUS  = 12'h004;
    localparam logic [11:0] OFF_DATA    = 12'h008;

    logic                aw_q, w_q, ar_q;
    logic [ADDR_W-1:0]   aw_addr_q, ar_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;

    logic                en_q, ovf_q, unf_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;

    logic                empty, full;
    logic                wr_commit, rd_commit;
    logic [DATA_W-1:0]   status_word;

    logic [1:0]          wr_resp, rd_resp;
    logic [DATA_W-1:0]   rd_data;
    logic                do_push, do_pop, set_ovf, set_unf, ctrl_we, clr_req;

    // Readies are held low while reset is asserted so nothing is accepted during it.
    assign s_axil_awready = !rst && !aw_q && !s_axil_bvalid;
    assign s_axil_wready  = !rst && !w_q && !s_axil_bvalid;
    assign s_axil_arready = !rst && !ar_q && !s_axil_rvalid;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign wr_commit = aw_q && w_q && !s_axil_bvalid;
    assign rd_commit = ar_q;

    always_comb begin
        status_word             = '0;
        status_word[0]          = empty;
        status_word[1]          = full;
        status_word[2]          = ovf_q;
        status_word[3]          = unf_q;
        status_word[4 +: CNT_W] = count;
    end

    always_comb begin
        wr_resp = RESP_SLVERR;
        do_push = 1'b0;
        set_ovf = 1'b0;
        ctrl_we = 1'b0;
        clr_req = 1'b0;
        if (wr_commit && (aw_addr_q[ADDR_W-1:12] == BASE_ADDR[ADDR_W-1:12])) begin
            case (aw_addr_q[11:0])
                OFF_CTRL: begin
                    wr_resp = RESP_OKAY;
                    if (w_strb_q[0]) begin
                        ctrl_we = 1'b1;
                        clr_req = w_data_q[1];
                    end
                end
                OFF_DATA: begin
                    // Partial strobes are rejected before the full check, so they never set ovf.
                    if (en_q && (&w_strb_q)) begin
                        if (full) begin
                            set_ovf = 1'b1;
                        end else begin
                            do_push = 1'b1;
                            wr_resp = RESP_OKAY;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_resp = RESP_SLVERR;
        rd_data = '0;
        do_pop  = 1'b0;
        set_unf = 1'b0;
        if (rd_commit && (ar_addr_q[ADDR_W-1:12] == BASE_ADDR[ADDR_W-1:12])) begin
            case (ar_addr_q[11:0])
                OFF_CTRL: begin
                    rd_resp = RESP_OKAY;
                    rd_data = DATA_W'(en_q);
                end
                OFF_STATUS: begin
                    rd_resp = RESP_OKAY;
                    rd_data = status_word;
                end
                OFF_DATA: begin
                    if (en_q) begin
                        if (empty) begin
                            set_unf = 1'b1;
                        end else begin
                            do_pop  = 1'b1;
                            rd_resp = RESP_OKAY;
                            rd_data = mem[rd_ptr];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= w_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_q          <= 1'b0;
            w_q           <= 1'b0;
            ar_q          <= 1'b0;
            aw_addr_q     <= '0;
            ar_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= '0;
            s_axil_rvalid <= 1'b0;
            s_axil_rresp  <= '0;
            s_axil_rdata  <= '0;
            en_q          <= 1'b0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            irq_not_empty <= 1'b0;
        end else begin
            if (s_axil_awvalid && s_axil_awready) begin
                aw_q      <= 1'b1;
                aw_addr_q <= s_axil_awaddr;
            end
            if (s_axil_wvalid && s_axil_wready) begin
                w_q      <= 1'b1;
                w_data_q <= s_axil_wdata;
                w_strb_q <= s_axil_wstrb;
            end
            if (wr_commit) begin
                aw_q          <= 1'b0;
                w_q           <= 1'b0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= wr_resp;
            end else if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end

            if (s_axil_arvalid && s_axil_arready) begin
                ar_q      <= 1'b1;
                ar_addr_q <= s_axil_araddr;
            end
            if (rd_commit) begin
                ar_q          <= 1'b0;
                s_axil_rvalid <= 1'b1;
                s_axil_rresp  <= rd_resp;
                s_axil_rdata  <= rd_data;
            end else if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end

            if (ctrl_we) begin
                en_q <= w_data_q[0];
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            if (set_ovf) begin
                ovf_q <= 1'b1;
            end
            if (set_unf) begin
                unf_q <= 1'b1;
            end
            // A clear overrides any push, pop or sticky update committing at the same edge.
            if (clr_req) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
            end
            irq_not_empty <= en_q && !empty;
        end
    end

endmodule

// File: tb/tb_axil_status_slave.sv
// Directed bench for axil_status_slave; drivers queue expected B/R responses and a
// negedge monitor compares every completed response against the queue head.
module tb_axil_status_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [31:0] A_CTRL   = 32'h0000_4000;
    localparam logic [31:0] A_STATUS = 32'h0000_4004;
    localparam logic [31:0] A_DATA   = 32'h0000_4008;

    logic        clk, rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, irq;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    logic [1:0]  exp_b_resp [$];
    string       exp_b_name [$];
    logic [1:0]  exp_r_resp [$];
    logic [31:0] exp_r_data [$];
    string       exp_r_name [$];
    string       mon_name;

    axil_status_slave dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .irq_not_empty  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout actual=no_handshake required=handshake", name);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bvalid && bready) begin
                if (exp_b_resp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_b actual=%0d required=none", bresp);
                end else begin
                    mon_name = exp_b_name.pop_front();
                    check({mon_name, " bresp"}, 32'(bresp), 32'(exp_b_resp.pop_front()));
                end
            end
            if (rvalid && rready) begin
                if (exp_r_resp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_r actual=%0d required=none", rresp);
                end else begin
                    mon_name = exp_r_name.pop_front();
                    check({mon_name, " rresp"}, 32'(rresp), 32'(exp_r_resp.pop_front()));
                    check({mon_name, " rdata"}, rdata, exp_r_data.pop_front());
                end
            end
        end
    end

    // All drivers start and end at 1 time unit after a rising edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp, input string name);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit a_hs, w_hs, b_hs;
        int n = 0;
        exp_b_resp.push_back(exp);
        exp_b_name.push_back(name);
        awaddr = addr; awvalid = 1'b1;
        wdata  = data; wstrb = strb; wvalid = 1'b1;
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            a_hs = awvalid && awready;
            w_hs = wvalid && wready;
            @(posedge clk); #1;
            if (a_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs) begin wvalid = 1'b0; w_done = 1'b1; end
            n++;
            if (n > 50) begin
                awvalid = 1'b0; wvalid = 1'b0;
                timeout({name, " aw/w"});
                return;
            end
        end
        n = 0;
        do begin
            @(negedge clk);
            b_hs = bvalid && bready;
            @(posedge clk); #1;
            n++;
        end while (!b_hs && n <= 50);
        if (!b_hs) timeout({name, " b"});
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [1:0] exp,
                            input logic [31:0] exp_data, input string name);
        bit ar_hs, r_hs;
        int n = 0;
        exp_r_resp.push_back(exp);
        exp_r_data.push_back(exp_data);
        exp_r_name.push_back(name);
        araddr = addr; arvalid = 1'b1;
        do begin
            @(negedge clk);
            ar_hs = arvalid && arready;
            @(posedge clk); #1;
            n++;
        end while (!ar_hs && n <= 50);
        arvalid = 1'b0;
        if (!ar_hs) begin
            timeout({name, " ar"});
            return;
        end
        n = 0;
        do begin
            @(negedge clk);
            r_hs = rvalid && rready;
            @(posedge clk); #1;
            n++;
        end while (!r_hs && n <= 50);
        if (!r_hs) timeout({name, " r"});
    endtask

    initial begin
        bit hs;
        int n;
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        araddr = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset awready", 32'(awready), 32'd0);
        check("reset arready", 32'(arready), 32'd0);
        check("reset bvalid", 32'(bvalid), 32'd0);
        check("reset rvalid", 32'(rvalid), 32'd0);
        check("reset irq", 32'(irq), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        axi_read(A_STATUS, OKAY, 32'h0000_0001, "status after reset");
        axi_read(A_CTRL, OKAY, 32'h0, "ctrl after reset");

        axi_write(A_CTRL, 32'h1, 4'hF, OKAY, "ctrl en");
        axi_write(A_DATA, 32'hA5A5_0001, 4'hF, OKAY, "push 1");
        axi_write(A_DATA, 32'hA5A5_0002, 4'hF, OKAY, "push 2");
        axi_read(A_STATUS, OKAY, 32'h0000_0020, "status count 2");
        check("irq with data", 32'(irq), 32'd1);
        axi_read(A_DATA, OKAY, 32'hA5A5_0001, "pop 1");
        axi_read(A_DATA, OKAY, 32'hA5A5_0002, "pop 2");
        @(posedge clk); #1;
        check("irq drained", 32'(irq), 32'd0);

        axi_write(A_DATA, 32'h1234_5678, 4'h3, SLVERR, "partial strobe");
        axi_read(A_STATUS, OKAY, 32'h0000_0001, "status after partial");

        for (int i = 0; i < 16; i++) begin
            axi_write(A_DATA, 32'h1000_0000 + 32'(i), 4'hF, OKAY, $sformatf("fill %0d", i));
        end
        axi_write(A_DATA, 32'hDEAD_BEEF, 4'hF, SLVERR, "push full");
        axi_read(A_STATUS, OKAY, 32'h0000_0106, "status full ovf");
        check("irq full", 32'(irq), 32'd1);
        axi_write(A_CTRL, 32'h3, 4'hF, OKAY, "ctrl clr");
        axi_read(A_STATUS, OKAY, 32'h0000_0001, "status after clr");
        axi_read(A_CTRL, OKAY, 32'h1, "ctrl clr reads 0");

        axi_read(A_DATA, SLVERR, 32'h0, "pop empty");
        axi_read(A_STATUS, OKAY, 32'h0000_0009, "status unf");
        axi_read(32'h0000_400C, SLVERR, 32'h0, "bad offset");
        axi_read(32'h0000_5000, SLVERR, 32'h0, "outside window");
        axi_write(A_STATUS, 32'hFFFF_FFFF, 4'hF, SLVERR, "write status");
        axi_write(32'h0000_400C, 32'h1, 4'hF, SLVERR, "write bad offset");
        axi_read(A_STATUS, OKAY, 32'h0000_0009, "status unchanged");

        axi_write(A_CTRL, 32'h0, 4'hF, OKAY, "ctrl disable");
        axi_write(A_DATA, 32'h5555_0000, 4'hF, SLVERR, "push disabled");
        axi_write(A_CTRL, 32'h3, 4'hE, OKAY, "ctrl lane0 off");
        axi_read(A_CTRL, OKAY, 32'h0, "ctrl ignores upper lanes");
        axi_read(A_STATUS, OKAY, 32'h0000_0009, "status disabled");
        axi_write(A_CTRL, 32'h3, 4'hF, OKAY, "ctrl en clr");

        axi_write(A_DATA, 32'hCAFE_0001, 4'hF, OKAY, "push x");
        fork
            axi_write(A_DATA, 32'hCAFE_0002, 4'hF, OKAY, "push y concurrent");
            axi_read(A_DATA, OKAY, 32'hCAFE_0001, "pop x concurrent");
        join
        axi_read(A_DATA, OKAY, 32'hCAFE_0002, "pop y");
        axi_read(A_STATUS, OKAY, 32'h0000_0001, "status order");

        // W three cycles ahead of AW, response held off by bready.
        bready = 1'b0;
        wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            hs = wvalid && wready;
            @(posedge clk); #1;
            n++;
        end while (!hs && n <= 50);
        wvalid = 1'b0;
        if (!hs) timeout("early w");
        repeat (2) @(posedge clk);
        #1;
        awaddr = A_CTRL; awvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            hs = awvalid && awready;
            @(posedge clk); #1;
            n++;
        end while (!hs && n <= 50);
        awvalid = 1'b0;
        if (!hs) timeout("late aw");
        check("bvalid at aw edge", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
        check("bvalid one edge later", 32'(bvalid), 32'd1);
        awaddr = A_DATA; awvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bvalid held %0d", i), 32'(bvalid), 32'd1);
            check($sformatf("bresp held %0d", i), 32'(bresp), 32'(OKAY));
            check($sformatf("awready blocked %0d", i), 32'(awready), 32'd0);
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        exp_b_resp.push_back(OKAY);
        exp_b_name.push_back("early w write");
        bready = 1'b1;
        @(posedge clk); #1;
        check("bvalid released", 32'(bvalid), 32'd0);
        axi_read(A_CTRL, OKAY, 32'h1, "ctrl after early w");

        // Reset with a read response pending and a write half latched.
        axi_write(A_DATA, 32'h0000_0077, 4'hF, OKAY, "push before reset");
        rready = 1'b0;
        araddr = A_STATUS; arvalid = 1'b1;
        wdata = 32'h0000_0099; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        check("rvalid before reset", 32'(rvalid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rvalid after reset", 32'(rvalid), 32'd0);
        check("bvalid after reset", 32'(bvalid), 32'd0);
        rst = 1'b0;
        rready = 1'b1;
        @(posedge clk); #1;
        axi_read(A_STATUS, OKAY, 32'h0000_0001, "status after mid reset");
        axi_read(A_CTRL, OKAY, 32'h0, "ctrl after mid reset");
        check("irq after mid reset", 32'(irq), 32'd0);
        axi_write(A_CTRL, 32'h1, 4'hF, OKAY, "ctrl after mid reset write");
        axi_read(A_CTRL, OKAY, 32'h1, "ctrl readback after mid reset");

        repeat (3) @(posedge clk);
        #1;
        check("b queue drained", 32'(exp_b_resp.size()), 32'd0);
        check("r queue drained", 32'(exp_r_resp.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
